baud_gen: RTL and testbench
===========================

Name: baud_gen

Overview:
- Programmable baud-rate tick generator for the UART SoC.
- Divides the system clock by a 16-bit divisor. The divisor is formed as {DLH, DLL} from the UART divisor-latch registers.
- Emits a one-clock-wide strobe `br` once every `div` clock cycles.
- `br` is the rate enable for the transmitter and receiver, typically the 16x oversample tick.

Parameters:
- DIV_W, 16, width of the divisor input and of the internal counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset. rst=0 at a rising edge resets the block.
- div  input  DIV_W  divisor {dlh,dll}. Treated as unsigned and quasi-static. It may change at any time.
- br  output  1  baud tick. Registered. High for exactly one clk cycle per period.

Behaviour:
- Internal state:
  - cnt[DIV_W-1:0], the cycle counter.
  - div_q[DIV_W-1:0], a shadow copy of div.
  - br, a register.
- Reset (rst=0 at a clk edge): cnt←0, br←0, div_q←div. Reset has priority over everything else.
- Each rising edge with rst=1, evaluated in this priority order:
  1. div != div_q (divisor changed): div_q←div, cnt←0, br←0. The count restarts from the new value; no partial period is produced.
  2. div_q == 0: cnt←0, br←0. Generator is disabled; br stays low indefinitely.
  3. cnt == div_q−1: cnt←0, br←1 (terminal count).
  4. Otherwise: cnt←cnt+1, br←0.
- Timing with a constant divisor N≥1 from reset release:
  - The first br pulse is registered on the N-th rising edge after the first edge with rst=1.
  - After that, br pulses every N edges: period N·Tclk, high time 1·Tclk.
- N=1: br is high on every cycle after the first edge with rst=1 (continuous high).
- N=0xFFFF: period is 65535 cycles. cnt never exceeds div_q−1, so there is no wrap past the maximum.
- Reset mid-period: br drops and cnt clears on that edge. The full N-cycle latency applies again after release.
- Divisor changed while br=1: br goes low on the change edge; the new period starts from cnt=0.
- No combinational path from div to br. br is a pure flop output.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared package, uart_pkg:
  - DIV_W = 16.
  - typedef divisor_t = logic [DIV_W-1:0].
  - Reset-value constant DIV_DISABLED = 0.
- No sub-module. A single counter/compare block; splitting it adds nothing.

Test Plan (clk period 10 ns):
- Nominal divisor:
  - Stimulus: rst=0 for one edge, then rst=1; dlh=0x00, dll=0x06 (div=6).
  - Required: first br high after the 6th edge post-release; then br high 1 cycle in every 6 (60 ns period). Check over ≥10 pulses.
- div=1:
  - Required: br=1 on every cycle after the first active edge.
- div=0:
  - Required: br remains 0 for ≥200 cycles.
  - Then set div=3: first br 3 edges after the change is sampled, then every 3 cycles.
- Divisor change mid-period:
  - Stimulus: div=6; change to div=4 two cycles after a pulse.
  - Required: no br on the change edge; next br 4 edges later; period 4 thereafter.
- Reset mid-operation:
  - Stimulus: div=6; assert rst=0 for 1 edge three cycles after a pulse.
  - Required: br=0 during reset; next pulse 6 edges after release.
- Large divisor:
  - Stimulus: div=0x0100.
  - Required: pulse spacing exactly 256 cycles. With div=0xFFFF, one interval measures 65535 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: divisor width, divisor type and the divisor value
// that disables the baud generator.
package uart_pkg;

    localparam int DIV_W = 16;

    typedef logic [DIV_W-1:0] divisor_t;

    localparam divisor_t DIV_DISABLED = '0;

endpackage : uart_pkg

// File: rtl/baud_gen.sv
// Programmable baud tick generator: emits a one-cycle strobe on br once every
// div clock cycles; div == 0 holds br low.
module baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W = uart_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    output logic             br
);

    localparam logic [DIV_W-1:0] ONE      = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DISABLED = DIV_W'(DIV_DISABLED);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;

    // A divisor change restarts the period from zero so that no shortened
    // pulse interval leaks out; cnt never exceeds div_q-1, so it cannot wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            br    <= 1'b0;
            div_q <= div;
        end else if (div != div_q) begin
            div_q <= div;
            cnt   <= '0;
            br    <= 1'b0;
        end else if (div_q == DISABLED) begin
            cnt <= '0;
            br  <= 1'b0;
        end else if (cnt == div_q - ONE) begin
            cnt <= '0;
            br  <= 1'b1;
        end else begin
            cnt <= cnt + ONE;
            br  <= 1'b0;
        end
    end

endmodule : baud_gen

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen: per-cycle vector table plus measured pulse
// intervals for long divisors, divisor changes and mid-period reset.
module tb_baud_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] div = 16'd0;
    logic        br;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic [15:0] div;
        logic        br;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    baud_gen #(.DIV_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .div (div),
        .br  (br)
    );

    // Inputs change 1 ns after a rising edge and outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_br(input string name, input logic exp);
        n_checks++;
        if (br !== exp) begin
            n_fail++;
            $display("FAIL %s: br=%b, expected %b", name, br, exp);
        end
    endtask

    // Count edges until br is sampled high; returns limit+1 on timeout.
    task automatic wait_pulse(input int limit, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (br !== 1'b1 && edges <= limit);
    endtask

    function automatic void add(input logic r, input logic [15:0] d, input logic b, input int n);
        vec_t v;
        v.rst = r;
        v.div = d;
        v.br  = b;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    initial begin
        int edges;
        int highs;

        // Cycle-by-cycle vectors: {rst, div, expected br after the edge}
        add(1'b0, 16'd6, 1'b0, 1);   // reset
        add(1'b1, 16'd6, 1'b0, 5);   // edges 1..5 after release
        add(1'b1, 16'd6, 1'b1, 1);   // 6th edge: first pulse
        add(1'b1, 16'd6, 1'b0, 5);
        add(1'b1, 16'd6, 1'b1, 1);
        add(1'b1, 16'd6, 1'b0, 2);   // two cycles after the pulse
        add(1'b1, 16'd4, 1'b0, 1);   // change edge: no pulse
        add(1'b1, 16'd4, 1'b0, 3);
        add(1'b1, 16'd4, 1'b1, 1);   // 4 edges after change
        add(1'b1, 16'd4, 1'b0, 3);
        add(1'b1, 16'd4, 1'b1, 1);
        add(1'b1, 16'd1, 1'b0, 1);   // change to div=1
        add(1'b1, 16'd1, 1'b1, 6);   // continuous high
        add(1'b0, 16'd1, 1'b0, 1);   // reset drops br
        add(1'b1, 16'd1, 1'b1, 3);   // div=1: high from first active edge
        add(1'b1, 16'd0, 1'b0, 1);   // change to disabled
        add(1'b1, 16'd0, 1'b0, 6);
        add(1'b1, 16'd2, 1'b0, 2);   // change edge, then cnt=1
        add(1'b1, 16'd2, 1'b1, 1);
        add(1'b1, 16'd2, 1'b0, 1);
        add(1'b1, 16'd2, 1'b1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            div = vecs[i].div;
            tick();
            check_br($sformatf("vec[%0d]", i), vecs[i].br);
        end

        // Nominal div=6 from reset, first latency and ten further intervals
        rst = 1'b0;
        div = 16'd6;
        tick();
        check_br("nom_reset", 1'b0);
        rst = 1'b1;
        wait_pulse(20, edges);
        check("nom_first", edges, 6);
        for (int p = 0; p < 10; p++) begin
            wait_pulse(20, edges);
            check($sformatf("nom_period[%0d]", p), edges, 6);
        end

        // Disabled for 200 cycles, then div=3
        div = 16'd0;
        tick();
        highs = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (br !== 1'b0) highs++;
        end
        check("div0_highs", highs, 0);
        div = 16'd3;
        tick();
        check_br("div3_chg_edge", 1'b0);
        wait_pulse(10, edges);
        check("div3_first", edges, 3);
        for (int p = 0; p < 3; p++) begin
            wait_pulse(10, edges);
            check($sformatf("div3_period[%0d]", p), edges, 3);
        end

        // Reset three cycles after a pulse
        div = 16'd6;
        wait_pulse(20, edges);
        repeat (3) tick();
        check_br("mid_pre_reset", 1'b0);
        rst = 1'b0;
        tick();
        check_br("mid_reset", 1'b0);
        rst = 1'b1;
        wait_pulse(20, edges);
        check("mid_after_release", edges, 6);

        // Divisor 0x0100
        div = 16'h0100;
        tick();
        check_br("d256_chg_edge", 1'b0);
        wait_pulse(300, edges);
        check("d256_first", edges, 256);
        for (int p = 0; p < 2; p++) begin
            wait_pulse(300, edges);
            check($sformatf("d256_period[%0d]", p), edges, 256);
        end

        // Maximum divisor: one full interval
        div = 16'hFFFF;
        tick();
        check_br("dmax_chg_edge", 1'b0);
        wait_pulse(65545, edges);
        check("dmax_interval", edges, 65535);
        tick();
        check_br("dmax_one_cycle", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_baud_gen
